// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   div_state_e   : controller states (IDLE, CALC, DONE)
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : iteration counter width for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_seq_addsub.sv
// N-bit adder/subtractor shared with the arithmetic library.
// Subtraction is done as a + ~b + 1; carry_o = 1 means "no borrow".
//   a_i, b_i    : operands
//   sub_flag_i  : 1 = subtract, 0 = add (also the carry-in)
//   sum_o       : N-bit result
//   carry_o     : carry out of the MSB
module addsub_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_flag_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);

  logic [N-1:0] b_eff;

  assign b_eff = b_i ^ {N{sub_flag_i}};
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{N{1'b0}}, sub_flag_i};

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n         : clock, async active-low reset
//   start              : request, sampled only in IDLE
//   dividend, divisor  : operands, sampled with start
//   busy               : high from accept until leaving DONE
//   done               : one-cycle pulse, results valid
//   quotient, remainder: registered results, held until next accept
//   div_by_zero        : set with done when divisor was 0
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring iteration per edge, dividend MSB first
// DONE  | done pulse, results valid
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             trial_msb_unused;

  // The running remainder is always below the divisor, so shifting in one
  // dividend bit needs only one extra bit of headroom.
  assign partial = {rem_q, dvd_q[WIDTH-1]};

  addsub_n #(
    .N (WIDTH + 1)
  ) u_trial_sub (
    .a_i        (partial),
    .b_i        ({1'b0, dvs_q}),
    .sub_flag_i (1'b1),
    .sum_o      (trial),
    .carry_o    (no_borrow)
  );

  // Whichever value is kept is below the divisor, so its top bit is zero.
  assign trial_msb_unused = trial[WIDTH];
  assign rem_d = no_borrow ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
  assign quo_d = {quo_q[WIDTH-2:0], no_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            cnt_q  <= '0;
            if (divisor == '0) begin
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              quo_q   <= '0;
              rem_q   <= '0;
              dbz_q   <= 1'b0;
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       st8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, q8, r8;
  logic       busy8, done8, z8;

  logic        st16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, q16, r16;
  logic        busy16, done16, z16;

  div_seq #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .start (st8), .dividend (a8), .divisor (b8),
    .busy (busy8), .done (done8), .quotient (q8), .remainder (r8), .div_by_zero (z8)
  );

  div_seq #(.WIDTH(16)) u_dut16 (
    .clk (clk), .rst_n (rst_n), .start (st16), .dividend (a16), .divisor (b16),
    .busy (busy16), .done (done16), .quotient (q16), .remainder (r16), .div_by_zero (z16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a, b, q, r;
    logic        z;
    int          lat;
    string       nm;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (w == 8) begin
      st8 = s; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      st16 = s; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  task automatic snap(input int w, output logic d, output logic bz,
                      output logic [31:0] q, output logic [31:0] r, output logic z);
    if (w == 8) begin
      d = done8; bz = busy8; q = {24'b0, q8}; r = {24'b0, r8}; z = z8;
    end else begin
      d = done16; bz = busy16; q = {16'b0, q16}; r = {16'b0, r16}; z = z16;
    end
  endtask

  // Reference: plain integer division; divide by zero gives all ones / dividend.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z,
                       output int lat);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    if (b == 0) begin
      q = mask; r = a; z = 1'b1; lat = 0;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = w;
    end
  endtask

  // lat = edges after the accepting edge until done is seen.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez,
                       input int elat, input string nm);
    logic d, bz, z;
    logic [31:0] q, r;
    int lat;
    drive(w, 1'b1, a, b);
    step();
    drive(w, 1'b0, $urandom, $urandom);
    snap(w, d, bz, q, r, z);
    chk({nm, " busy_at_accept"}, {63'b0, bz}, 64'd1);
    lat = 0;
    while (!d && lat < 40) begin
      step();
      lat++;
      snap(w, d, bz, q, r, z);
    end
    chk({nm, " latency"}, lat, elat);
    chk({nm, " quotient"}, q, eq);
    chk({nm, " remainder"}, r, er);
    chk({nm, " div_by_zero"}, {63'b0, z}, {63'b0, ez});
    if (!ez) begin
      chk({nm, " invariant"}, 64'(q) * 64'(b) + 64'(r), 64'(a));
      chk({nm, " rem_lt_div"}, {63'b0, (r < b)}, 64'd1);
    end
    step();
    snap(w, d, bz, q, r, z);
    chk({nm, " done_pulse_end"}, {62'b0, d, bz}, 64'd0);
    chk({nm, " quotient_held"}, q, eq);
    chk({nm, " flag_held"}, {63'b0, z}, {63'b0, ez});
  endtask

  task automatic rand_run(input int w, input int n);
    logic [31:0] a, b, q, r, mask;
    logic z;
    int lat;
    mask = (32'd1 << w) - 1;
    for (int i = 0; i < n; i++) begin
      a = $urandom & mask;
      b = $urandom & mask;
      if (i % 50 == 0) b = 0;
      else if (i % 4 == 0) b = $urandom_range(1, 15);
      model(w, a, b, q, r, z, lat);
      do_op(w, a, b, q, r, z, lat, (w == 8) ? "rand8" : "rand16");
    end
  endtask

  initial begin
    logic d, bz, z;
    logic [31:0] q, r;
    int lat;

    tbl[0] = '{a: 200, b: 7,   q: 28,  r: 4,   z: 0, lat: 8, nm: "200/7"};
    tbl[1] = '{a: 5,   b: 9,   q: 0,   r: 5,   z: 0, lat: 8, nm: "5/9"};
    tbl[2] = '{a: 255, b: 1,   q: 255, r: 0,   z: 0, lat: 8, nm: "255/1"};
    tbl[3] = '{a: 255, b: 255, q: 1,   r: 0,   z: 0, lat: 8, nm: "255/255"};
    tbl[4] = '{a: 100, b: 0,   q: 255, r: 100, z: 1, lat: 0, nm: "100/0"};
    tbl[5] = '{a: 13,  b: 3,   q: 4,   r: 1,   z: 0, lat: 8, nm: "13/3_after_dbz"};
    tbl[6] = '{a: 0,   b: 5,   q: 0,   r: 0,   z: 0, lat: 8, nm: "0/5"};
    tbl[7] = '{a: 128, b: 2,   q: 64,  r: 0,   z: 0, lat: 8, nm: "128/2"};
    tbl[8] = '{a: 0,   b: 0,   q: 255, r: 0,   z: 1, lat: 0, nm: "0/0"};

    #2 rst_n = 1'b0;
    #11;
    chk("reset_outputs8", {busy8, done8, z8, q8, r8}, 64'd0);
    chk("reset_outputs16", {busy16, done16, z16, q16, r16}, 64'd0);
    #9 rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      do_op(8, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].lat, tbl[i].nm);

    // start held high, operands change mid-op: one result, then back-to-back accept
    drive(8, 1'b1, 200, 7);
    step();
    drive(8, 1'b1, 50, 3);
    lat = 0;
    snap(8, d, bz, q, r, z);
    while (!d && lat < 40) begin
      step(); lat++; snap(8, d, bz, q, r, z);
    end
    chk("held latency", lat, 8);
    chk("held quotient", q, 28);
    chk("held remainder", r, 4);
    step();
    snap(8, d, bz, q, r, z);
    chk("held idle_after_done", {62'b0, d, bz}, 64'd0);
    step();
    snap(8, d, bz, q, r, z);
    chk("b2b accepted", {63'b0, bz}, 64'd1);
    drive(8, 1'b0, 0, 0);
    lat = 0;
    while (!d && lat < 40) begin
      step(); lat++; snap(8, d, bz, q, r, z);
    end
    chk("b2b latency", lat, 8);
    chk("b2b quotient", q, 16);
    chk("b2b remainder", r, 2);
    step();

    // reset in the middle of CALC
    drive(8, 1'b1, 200, 7);
    step();
    drive(8, 1'b0, 0, 0);
    step(); step(); step();
    #1 rst_n = 1'b0;
    #1;
    chk("midreset outputs", {busy8, done8, z8, q8, r8}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midreset no_done", {63'b0, done8}, 64'd0);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("postreset quiet", {62'b0, done8, busy8}, 64'd0);
    end
    do_op(8, 13, 3, 4, 1, 1'b0, 8, "13/3_after_reset");

    fork
      rand_run(8, 2500);
      rand_run(16, 2500);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
